// File: rtl/sram_like_responder.sv
// SRAM-like bus slave: in-order outstanding queue backed by a byte-strobed word memory.
// Define SRAM_RAND_DELAY_EN to add LFSR jitter to the address-accept and response delays.
module sram_like_responder #(
    parameter int ADDR_W     = 12,
    parameter int DEPTH      = 4,
    parameter int ADDR_DELAY = 0,
    parameter int DATA_DELAY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DLY_W = $clog2(DATA_DELAY + 4);
    localparam int AW_W  = $clog2(ADDR_DELAY + 4);

    logic [31:0]       r_mem [2**ADDR_W];
    logic              r_q_wr   [DEPTH];
    logic [31:0]       r_q_data [DEPTH];
    logic [DLY_W-1:0]  r_q_cnt  [DEPTH];
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [AW_W-1:0]   r_addr_wait;
    logic              r_data_ok;
    logic [31:0]       r_rdata;

    logic [ADDR_W-1:0] w_idx;
    logic [31:0]       w_rd_word;
    logic              w_hs;
    logic              w_head_rdy;
    logic              w_bypass;
    logic              w_push;
    logic              w_pop;
    logic [DLY_W-1:0]  w_load;
    logic [DLY_W-1:0]  w_stored;
    logic [AW_W-1:0]   w_wait_load;
    logic              w_unused;

    function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef SRAM_RAND_DELAY_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    assign w_load      = DLY_W'(DATA_DELAY - 1) + DLY_W'(r_lfsr[3:2]);
    assign w_wait_load = AW_W'(ADDR_DELAY) + AW_W'(r_lfsr[1:0]);
`else
    assign w_load      = DLY_W'(DATA_DELAY - 1);
    assign w_wait_load = AW_W'(ADDR_DELAY);
`endif

    // Handshake: a request transfers in any cycle where req & addr_ok; data_ok is a
    // one-cycle pulse the initiator must always take, one per accepted request, in order.
    assign addr_ok    = req & (r_addr_wait == '0) & (r_count < CNT_W'(DEPTH)) & ~reset;
    assign w_hs       = req & addr_ok;
    assign w_idx      = addr[ADDR_W+1:2];
    assign w_rd_word  = r_mem[w_idx];
    assign w_head_rdy = (r_count != '0) && (r_q_cnt[r_head] == '0);
    assign w_pop      = w_head_rdy;
    // An entry whose countdown is already zero on an empty queue answers straight away.
    assign w_bypass   = w_hs && (r_count == '0) && (w_load == '0);
    assign w_push     = w_hs && !w_bypass;
    assign w_stored   = (w_load == '0) ? '0 : w_load - 1'b1;
    assign w_unused   = ^{size, addr[31:ADDR_W+2], addr[1:0]};

    always_ff @(posedge clk) begin
        if (w_hs && wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    r_mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (r_q_cnt[i] != '0) begin
                r_q_cnt[i] <= r_q_cnt[i] - 1'b1;
            end
        end
        if (w_push) begin
            r_q_wr[r_tail]   <= wr;
            r_q_data[r_tail] <= wr ? 32'd0 : w_rd_word;
            r_q_cnt[r_tail]  <= w_stored;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_addr_wait <= AW_W'(ADDR_DELAY);
            r_data_ok   <= 1'b0;
            r_rdata     <= 32'd0;
        end else begin
            if (w_hs) begin
                r_addr_wait <= w_wait_load;
            end else if (req && r_addr_wait != '0) begin
                r_addr_wait <= r_addr_wait - 1'b1;
            end

            if (w_push) begin
                r_tail <= f_next(r_tail);
            end
            if (w_pop) begin
                r_head <= f_next(r_head);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            r_data_ok <= w_pop | w_bypass;
            if (w_pop) begin
                r_rdata <= r_q_wr[r_head] ? 32'd0 : r_q_data[r_head];
            end else if (w_bypass) begin
                r_rdata <= wr ? 32'd0 : w_rd_word;
            end
        end
    end

    assign data_ok = r_data_ok;
    assign rdata   = r_rdata;
endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder: directed vector table, queue/delay/reset sequences and
// a randomized run against a word-array reference model.
module tb_sram_like_responder;
    localparam int Q_DEPTH = 4;
    localparam int Q_DD    = 6;
    localparam int Q_AD    = 0;
    localparam int N_RAND  = 200;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // u_d: defaults
    logic d_rst, d_req, d_wr, d_addr_ok, d_data_ok;
    logic [1:0] d_size;
    logic [3:0] d_wstrb;
    logic [31:0] d_addr, d_wdata, d_rdata;
    // u_q: deep latency, queue fills
    logic q_rst, q_req, q_wr, q_addr_ok, q_data_ok;
    logic [1:0] q_size;
    logic [3:0] q_wstrb;
    logic [31:0] q_addr, q_wdata, q_rdata;
    // u_a: address delay
    logic a_rst, a_req, a_wr, a_addr_ok, a_data_ok;
    logic [1:0] a_size;
    logic [3:0] a_wstrb;
    logic [31:0] a_addr, a_wdata, a_rdata;
    // u_t: reset while responses are pending
    logic t_rst, t_req, t_wr, t_addr_ok, t_data_ok;
    logic [1:0] t_size;
    logic [3:0] t_wstrb;
    logic [31:0] t_addr, t_wdata, t_rdata;

    sram_like_responder u_d (
        .clk(clk), .reset(d_rst), .req(d_req), .wr(d_wr), .size(d_size), .wstrb(d_wstrb),
        .addr(d_addr), .wdata(d_wdata), .addr_ok(d_addr_ok), .data_ok(d_data_ok), .rdata(d_rdata)
    );

    sram_like_responder #(.DEPTH(Q_DEPTH), .ADDR_DELAY(Q_AD), .DATA_DELAY(Q_DD)) u_q (
        .clk(clk), .reset(q_rst), .req(q_req), .wr(q_wr), .size(q_size), .wstrb(q_wstrb),
        .addr(q_addr), .wdata(q_wdata), .addr_ok(q_addr_ok), .data_ok(q_data_ok), .rdata(q_rdata)
    );

    sram_like_responder #(.ADDR_DELAY(2), .DATA_DELAY(4)) u_a (
        .clk(clk), .reset(a_rst), .req(a_req), .wr(a_wr), .size(a_size), .wstrb(a_wstrb),
        .addr(a_addr), .wdata(a_wdata), .addr_ok(a_addr_ok), .data_ok(a_data_ok), .rdata(a_rdata)
    );

    sram_like_responder #(.DATA_DELAY(4)) u_t (
        .clk(clk), .reset(t_rst), .req(t_req), .wr(t_wr), .size(t_size), .wstrb(t_wstrb),
        .addr(t_addr), .wdata(t_wdata), .addr_ok(t_addr_ok), .data_ok(t_data_ok), .rdata(t_rdata)
    );

    typedef struct {
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[10];
    logic [31:0] exp_q[$];
    int          exp_cyc_q[$];
    logic [31:0] mm[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic a_txn(input logic w, input logic [31:0] ad, input logic [31:0] wd,
                         input logic [31:0] exp);
        @(posedge clk); #1;
        a_req = 1'b1; a_wr = w; a_wstrb = 4'hF; a_addr = ad; a_wdata = wd;
        @(negedge clk); check("a_wait_c0", 32'(a_addr_ok), 32'd0);
        @(posedge clk); #1;
        @(negedge clk); check("a_wait_c1", 32'(a_addr_ok), 32'd0);
        @(posedge clk); #1;
        @(negedge clk); check("a_aok_c2", 32'(a_addr_ok), 32'd1);
        @(posedge clk); #1;
        a_req = 1'b0;
        for (int t = 1; t < 4; t++) begin
            @(negedge clk); check("a_dok_early", 32'(a_data_ok), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("a_dok", 32'(a_data_ok), 32'd1);
        check("a_rdata", a_rdata, exp);
    endtask

    initial begin
        int          n_acc, n_dok, since_hs, outst, ec, start, rel;
        logic [31:0] ed;
        logic [2:0]  widx;
        logic        got, done;
        int          acc_log[6];
        int          exp_acc[6];

        {d_req, d_wr, d_size, d_wstrb, d_addr, d_wdata} = '0;
        {q_req, q_wr, q_size, q_wstrb, q_addr, q_wdata} = '0;
        {a_req, a_wr, a_size, a_wstrb, a_addr, a_wdata} = '0;
        {t_req, t_wr, t_size, t_wstrb, t_addr, t_wdata} = '0;
        d_size = 2'd2; q_size = 2'd2; a_size = 2'd2; t_size = 2'd2;
        {d_rst, q_rst, a_rst, t_rst} = 4'hF;

        vecs[0] = '{1'b1, 4'hF,    32'h0000_0010, 32'h1122_3344, 32'h0000_0000};
        vecs[1] = '{1'b0, 4'h0,    32'h0000_0010, 32'h0,         32'h1122_3344};
        vecs[2] = '{1'b1, 4'b0010, 32'h0000_0010, 32'h0000_AB00, 32'h0000_0000};
        vecs[3] = '{1'b0, 4'h0,    32'h0000_0010, 32'h0,         32'h1122_AB44};
        vecs[4] = '{1'b1, 4'h0,    32'h0000_0010, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[5] = '{1'b0, 4'h0,    32'h0000_0010, 32'h0,         32'h1122_AB44};
        vecs[6] = '{1'b1, 4'hF,    32'h0000_0014, 32'hDEAD_BEEF, 32'h0000_0000};
        vecs[7] = '{1'b0, 4'h0,    32'h0000_4013, 32'h0,         32'h1122_AB44};
        vecs[8] = '{1'b1, 4'b1001, 32'h0000_0014, 32'h5500_0066, 32'h0000_0000};
        vecs[9] = '{1'b0, 4'h0,    32'h0000_0014, 32'h0,         32'h55AD_BE66};

        repeat (2) @(posedge clk);
        #1;
        {d_rst, q_rst, a_rst, t_rst} = 4'h0;
        @(negedge clk);
        check("rst_aok", 32'(d_addr_ok), 32'd0);
        check("rst_dok", 32'(d_data_ok), 32'd0);
        check("rst_rdata", d_rdata, 32'd0);
        check("rst_count", 32'(u_t.r_count), 32'd0);
        check("rst_addr_wait", 32'(u_a.r_addr_wait), 32'd2);

`ifndef SRAM_RAND_DELAY_EN
        // Single transactions with default delays.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            d_req = 1'b1; d_wr = vecs[i].wr; d_wstrb = vecs[i].wstrb;
            d_addr = vecs[i].addr; d_wdata = vecs[i].wdata;
            @(negedge clk);
            check("tbl_aok", 32'(d_addr_ok), 32'd1);
            check("tbl_dok_idle", 32'(d_data_ok), 32'd0);
            @(posedge clk); #1;
            d_req = 1'b0;
            @(negedge clk);
            check("tbl_dok", 32'(d_data_ok), 32'd1);
            check("tbl_rdata", d_rdata, vecs[i].exp);
        end

        // Back-to-back reads with req held.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            d_req = 1'b1; d_wr = 1'b0; d_addr = (i % 2 == 0) ? 32'h10 : 32'h14;
            @(negedge clk);
            check("b2b_aok", 32'(d_addr_ok), 32'd1);
            check("b2b_dok", 32'(d_data_ok), 32'(i > 0));
            if (i > 0) check("b2b_rdata", d_rdata, (i % 2 == 1) ? 32'h1122_AB44 : 32'h55AD_BE66);
        end
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk);
        check("b2b_last_dok", 32'(d_data_ok), 32'd1);
        check("b2b_last_rdata", d_rdata, 32'h55AD_BE66);

        // Queue fill: 6 reads held against DEPTH=4, DATA_DELAY=6.
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            q_req = 1'b1; q_wr = 1'b1; q_wstrb = 4'hF;
            q_addr = 32'h100 + 32'(k * 4); q_wdata = 32'hA5A5_0000 + 32'(k);
            @(negedge clk); check("q_pre_aok", 32'(q_addr_ok), 32'd1);
            @(posedge clk); #1;
            q_req = 1'b0;
            got = 1'b0;
            for (int t = 0; t < 10 && !got; t++) begin
                @(negedge clk);
                if (q_data_ok) got = 1'b1;
                else @(posedge clk);
            end
            check("q_pre_dok", 32'(got), 32'd1);
        end
        exp_acc = '{0, 1, 2, 3, 6, 7};
        @(posedge clk); #1;
        q_req = 1'b1; q_wr = 1'b0; q_addr = 32'h100;
        start = cyc; n_acc = 0; n_dok = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            rel = cyc - start;
            if (q_data_ok) begin
                n_dok++;
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL q_spurious_dok: actual data_ok=1 required 0 at rel cycle %0d", rel);
                end else begin
                    ed = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
                    check("q_rdata", q_rdata, ed);
                    check("q_dok_cycle", 32'(rel), 32'(ec));
                end
            end
            if (q_req && q_addr_ok) begin
                acc_log[n_acc] = rel;
                exp_q.push_back(32'hA5A5_0000 + 32'(n_acc));
                exp_cyc_q.push_back(rel + Q_DD);
                n_acc++;
            end
            @(posedge clk); #1;
            if (n_acc == 6) q_req = 1'b0;
            else q_addr = 32'h100 + 32'(n_acc * 4);
        end
        check("q_n_acc", 32'(n_acc), 32'd6);
        for (int k = 0; k < 6; k++) check("q_acc_cycle", 32'(acc_log[k]), 32'(exp_acc[k]));
        check("q_n_dok", 32'(n_dok), 32'd6);
        exp_q.delete(); exp_cyc_q.delete();

        // Address delay of 2: write then read back.
        a_txn(1'b1, 32'h40, 32'hCAFE_F00D, 32'h0);
        a_txn(1'b0, 32'h40, 32'h0, 32'hCAFE_F00D);

        // Reset with three reads pending.
        @(posedge clk); #1;
        t_req = 1'b1; t_wr = 1'b1; t_wstrb = 4'hF; t_addr = 32'h80; t_wdata = 32'h0BAD_F00D;
        @(negedge clk); check("t_wr_aok", 32'(t_addr_ok), 32'd1);
        @(posedge clk); #1;
        t_req = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 10 && !got; t++) begin
            @(negedge clk);
            if (t_data_ok) got = 1'b1;
            else @(posedge clk);
        end
        check("t_wr_dok", 32'(got), 32'd1);
        @(posedge clk); #1;
        t_req = 1'b1; t_wr = 1'b0; t_addr = 32'h80;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); check("t_rd_aok", 32'(t_addr_ok), 32'd1);
            @(posedge clk); #1;
        end
        t_req = 1'b0; t_rst = 1'b1;
        @(negedge clk); check("t_dok_in_rst", 32'(t_data_ok), 32'd0);
        @(posedge clk); #1;
        t_rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); check("t_no_dok", 32'(t_data_ok), 32'd0);
            @(posedge clk); #1;
        end
        check("t_count", 32'(u_t.r_count), 32'd0);
        check("t_rdata_rst", t_rdata, 32'd0);
        t_req = 1'b1; t_wr = 1'b0; t_addr = 32'h80;
        @(negedge clk); check("t_rd2_aok", 32'(t_addr_ok), 32'd1);
        @(posedge clk); #1;
        t_req = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 10 && !got; t++) begin
            @(negedge clk);
            if (t_data_ok) got = 1'b1;
            else @(posedge clk);
        end
        check("t_rd2_dok", 32'(got), 32'd1);
        check("t_rd2_rdata", t_rdata, 32'h0BAD_F00D);
`endif

        // Randomized traffic on u_q against the word-array model.
        n_acc = 0; n_dok = 0; since_hs = 0; done = 1'b0;
        for (int bud = 0; bud < 6000 && !done; bud++) begin
            @(posedge clk); #1;
            if (n_acc < N_RAND) begin
                q_req   = ($urandom_range(0, 3) != 0);
                widx    = 3'($urandom_range(0, 7));
                q_addr  = ($urandom & 32'hFFFF_C000) | {27'd0, widx, 2'b00} | 32'($urandom_range(0, 3));
                q_wdata = $urandom;
                if (n_acc < 8) begin
                    q_wr = 1'b1; q_wstrb = 4'hF; q_addr = {27'd0, 3'(n_acc), 2'b00};
                end else begin
                    q_wr = 1'($urandom_range(0, 1)); q_wstrb = 4'($urandom_range(0, 15));
                end
            end else begin
                q_req = 1'b0;
            end
            @(negedge clk);
            if (q_data_ok) begin
                n_dok++;
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL rnd_spurious_dok: actual data_ok=1 required 0 at cycle %0d", cyc);
                end else begin
                    ed = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
                    check("rnd_rdata", q_rdata, ed);
`ifdef SRAM_RAND_DELAY_EN
                    check("rnd_lat_min", 32'(cyc >= ec), 32'd1);
`else
                    check("rnd_lat", 32'(cyc), 32'(ec));
`endif
                end
            end
            outst = n_acc - n_dok;
`ifdef SRAM_RAND_DELAY_EN
            if (q_addr_ok) check("rnd_full_block", 32'(outst < Q_DEPTH), 32'd1);
`else
            check("rnd_addr_ok", 32'(q_addr_ok), 32'(q_req && since_hs >= Q_AD && outst < Q_DEPTH));
`endif
            if (q_req && q_addr_ok) begin
                widx = q_addr[4:2];
                if (q_wr) begin
                    for (int k = 0; k < 4; k++)
                        if (q_wstrb[k]) mm[widx][8*k +: 8] = q_wdata[8*k +: 8];
                    exp_q.push_back(32'd0);
                end else begin
                    exp_q.push_back(mm[widx]);
                end
                exp_cyc_q.push_back(cyc + Q_DD);
                n_acc++;
                since_hs = 0;
            end else if (q_req) begin
                since_hs++;
            end
            done = (n_acc >= N_RAND) && (n_dok == n_acc);
        end
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL rnd_timeout: actual %0d accepts %0d responses required %0d each", n_acc, n_dok, N_RAND);
        end
        check("rnd_n_dok", 32'(n_dok), 32'(N_RAND));
        check("rnd_left", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
